bitonic_loader4: RTL and testbench

Upstream feeder for the 4-input bitonic merger (BM4). Accepts a serial stream of DATA_WIDTH-bit words over a valid/ready handshake, gathers groups of four, and compare-swaps the two halves into a bitonic sequence: first pair ascending, second pair descending. It presents the result as four parallel words plus the captured sort direction, and holds them until the merger side accepts.

---
 rtl/bitonic_loader4_if.sv | 45 ++++
 rtl/bitonic_loader4.sv | 76 +++++++
 tb/tb_bitonic_loader4.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/bitonic_loader4_if.sv
// Handshake and data bundle between the serial word stream, the loader and the BM4 merger.
// The slave modport is the loader's view; the master modport drives the loader.
interface bitonic_loader4_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_dir;
  logic [DATA_WIDTH-1:0] o1;
  logic [DATA_WIDTH-1:0] o2;
  logic [DATA_WIDTH-1:0] o3;
  logic [DATA_WIDTH-1:0] o4;
  logic                  out_dir;
  logic                  out_valid;
  logic                  out_ready;

  modport slave (
    input  in_data,
    input  in_valid,
    input  in_dir,
    input  out_ready,
    output in_ready,
    output o1,
    output o2,
    output o3,
    output o4,
    output out_dir,
    output out_valid
  );

  modport master (
    output in_data,
    output in_valid,
    output in_dir,
    output out_ready,
    input  in_ready,
    input  o1,
    input  o2,
    input  o3,
    input  o4,
    input  out_dir,
    input  out_valid
  );
endinterface

// File: rtl/bitonic_loader4.sv
// Gathers four stream words and compare-swaps them into a bitonic group
// (first pair ascending, second pair descending) for the 4-input bitonic merger.
module bitonic_loader4 #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  bitonic_loader4_if.slave   bus
);

  typedef enum logic [1:0] {StFill, StSort, StHold} state_e;

  state_e                state_q, state_d;
  logic [1:0]            cnt_q;
  logic [DATA_WIDTH-1:0] slot_q [4];
  logic                  dir_q;
  logic [DATA_WIDTH-1:0] o1_q, o2_q, o3_q, o4_q;
  logic                  out_dir_q;
  logic                  accept;
  logic                  swap_a;
  logic                  keep_b;

  // Gating with rst keeps the stream stalled while reset is held.
  assign bus.in_ready  = (state_q == StFill) && rst;
  assign bus.out_valid = (state_q == StHold);
  assign accept        = bus.in_valid && bus.in_ready;

  assign bus.o1      = o1_q;
  assign bus.o2      = o2_q;
  assign bus.o3      = o3_q;
  assign bus.o4      = o4_q;
  assign bus.out_dir = out_dir_q;

  assign swap_a = slot_q[0] > slot_q[1];
  assign keep_b = slot_q[2] >= slot_q[3];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFill:  if (accept && (cnt_q == 2'd3)) state_d = StSort;
      StSort:  state_d = StHold;
      StHold:  if (bus.out_ready) state_d = StFill;
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StFill;
      cnt_q     <= 2'd0;
      dir_q     <= 1'b0;
      out_dir_q <= 1'b0;
      o1_q      <= '0;
      o2_q      <= '0;
      o3_q      <= '0;
      o4_q      <= '0;
      for (int i = 0; i < 4; i++) slot_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        slot_q[cnt_q] <= bus.in_data;
        // Wraps from 3 back to 0 as the group completes.
        cnt_q         <= cnt_q + 2'd1;
        if (cnt_q == 2'd0) dir_q <= bus.in_dir;
      end
      if (state_q == StSort) begin
        o1_q      <= swap_a ? slot_q[1] : slot_q[0];
        o2_q      <= swap_a ? slot_q[0] : slot_q[1];
        o3_q      <= keep_b ? slot_q[2] : slot_q[3];
        o4_q      <= keep_b ? slot_q[3] : slot_q[2];
        out_dir_q <= dir_q;
      end
    end
  end

endmodule

// File: tb/tb_bitonic_loader4.sv
// Directed, table-driven bench for bitonic_loader4 with hand-written
// reset, backpressure, gapped-input and mid-group-reset sequences.
module tb_bitonic_loader4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_total = 0;
  int   n_pass  = 0;

  bitonic_loader4_if #(.DATA_WIDTH(32)) bus ();

  bitonic_loader4 #(.DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w [4];
    logic        d;
    logic [31:0] e [4];
    logic        ed;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic chk_outs(input string tag, input logic [31:0] e [4], input logic ed);
    chk({tag, " o1"}, bus.o1, e[0]);
    chk({tag, " o2"}, bus.o2, e[1]);
    chk({tag, " o3"}, bus.o3, e[2]);
    chk({tag, " o4"}, bus.o4, e[3]);
    chk({tag, " out_dir"}, {31'd0, bus.out_dir}, {31'd0, ed});
  endtask

  // Called at a negedge; returns at the negedge after the word is accepted.
  task automatic put_word(input string tag, input logic [31:0] w, input logic d);
    int n = 0;
    bus.in_data  = w;
    bus.in_dir   = d;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_total++;
      $display("FAIL %s put_word timeout: in_ready stuck at 0, required 1", tag);
    end
    @(negedge clk);
  endtask

  task automatic do_group(input string tag, input logic [31:0] w [4], input logic d,
                          input bit gapped, input logic [31:0] e [4], input logic ed);
    for (int i = 0; i < 4; i++) begin
      put_word(tag, w[i], (i == 0) ? d : ~d);
      if (gapped && i < 3) begin
        bus.in_valid = 1'b0;
        @(negedge clk);
      end
    end
    bus.in_valid = 1'b0;
    chk({tag, " sort out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, " sort in_ready"}, {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk);
    chk({tag, " hold out_valid"}, {31'd0, bus.out_valid}, 32'd1);
    chk_outs(tag, e, ed);
    if (bus.out_ready) begin
      @(negedge clk);
      chk({tag, " post out_valid"}, {31'd0, bus.out_valid}, 32'd0);
      chk({tag, " post in_ready"}, {31'd0, bus.in_ready}, 32'd1);
      chk({tag, " post o1 held"}, bus.o1, e[0]);
    end
  endtask

  vec_t        vecs [4];
  logic [31:0] zero4 [4];
  logic [31:0] exp4 [4];
  logic [31:0] w4 [4];

  initial begin
    vecs[0] = '{w: '{32'd6, 32'd5, 32'd4, 32'd3}, d: 1'b1,
                e: '{32'd5, 32'd6, 32'd4, 32'd3}, ed: 1'b1};
    vecs[1] = '{w: '{32'd1, 32'd9, 32'd7, 32'd8}, d: 1'b0,
                e: '{32'd1, 32'd9, 32'd8, 32'd7}, ed: 1'b0};
    vecs[2] = '{w: '{32'd7, 32'd7, 32'd7, 32'd7}, d: 1'b1,
                e: '{32'd7, 32'd7, 32'd7, 32'd7}, ed: 1'b1};
    vecs[3] = '{w: '{32'hFFFF_FFFF, 32'd1, 32'd0, 32'h8000_0000}, d: 1'b0,
                e: '{32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0}, ed: 1'b0};
    zero4 = '{32'd0, 32'd0, 32'd0, 32'd0};

    // Reset held with a valid word pending.
    bus.in_data   = 32'hDEAD_BEEF;
    bus.in_valid  = 1'b1;
    bus.in_dir    = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("reset in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk_outs("reset", zero4, 1'b0);
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("release in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("release out_valid", {31'd0, bus.out_valid}, 32'd0);

    for (int v = 0; v < 4; v++) begin
      do_group($sformatf("vec%0d", v), vecs[v].w, vecs[v].d, 1'b0, vecs[v].e, vecs[v].ed);
    end

    // Backpressure: hold for 10 cycles with a word waiting upstream.
    bus.out_ready = 1'b0;
    w4   = '{32'd11, 32'd12, 32'd13, 32'd14};
    exp4 = '{32'd11, 32'd12, 32'd14, 32'd13};
    do_group("bp", w4, 1'b1, 1'b0, exp4, 1'b1);
    bus.in_data  = 32'd99;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("bp out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk_outs("bp stable", exp4, 1'b1);
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    @(negedge clk);
    chk("bp accept out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("bp accept in_ready", {31'd0, bus.in_ready}, 32'd1);
    w4   = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0};
    exp4 = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0};
    do_group("bp next", w4, 1'b0, 1'b0, exp4, 1'b0);

    // Gapped input, direction flips after the first word.
    w4   = '{32'd2, 32'd3, 32'd1, 32'd4};
    exp4 = '{32'd2, 32'd3, 32'd4, 32'd1};
    do_group("gap", w4, 1'b0, 1'b1, exp4, 1'b0);

    // Mid-group reset discards the partial group.
    put_word("mid", 32'd55, 1'b0);
    put_word("mid", 32'd66, 1'b0);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("mid reset in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk_outs("mid reset", zero4, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    w4   = '{32'd10, 32'd20, 32'd30, 32'd40};
    exp4 = '{32'd10, 32'd20, 32'd40, 32'd30};
    do_group("mid", w4, 1'b1, 1'b0, exp4, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: simulation still running, required finish");
    $fatal(1, "timeout");
  end

endmodule
